// File: rtl/phase_acc_pkg.sv
// Shared definitions for the phase accumulator (NCO front end).
//   SAW_W     : width of the sawtooth phase word handed to saw2sin
//   ACC_W_DEF : default accumulator width
//   ftw_t     : tuning-word type at the default accumulator width
package phase_acc_pkg;

  localparam int unsigned SAW_W     = 16;
  localparam int unsigned ACC_W_DEF = 32;

  typedef logic [ACC_W_DEF-1:0] ftw_t;

endpackage

// File: rtl/ftw_shadow.sv
// Double-buffered frequency tuning word.
// A load lands in the shadow register and raises pend. The shadow moves
// into the active word only at a phase wrap or on sync.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_wrap         : current step carries out of the accumulator
//   i_sync         : phase sync (commits pending word immediately)
//   i_load, i_ftw  : shadow load strobe and value
//   o_ftw_act      : tuning word in use by the accumulator
//   o_pend         : shadow loaded but not yet committed
module ftw_shadow #(
  parameter int unsigned ACC_W = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_wrap,
  input  logic             i_sync,
  input  logic             i_load,
  input  logic [ACC_W-1:0] i_ftw,
  output logic [ACC_W-1:0] o_ftw_act,
  output logic             o_pend
);

  logic [ACC_W-1:0] act_q, act_d;
  logic [ACC_W-1:0] shd_q, shd_d;
  logic             pend_q, pend_d;

  always_comb begin
    act_d  = act_q;
    shd_d  = shd_q;
    pend_d = pend_q;
    if (i_sync) begin
      if (i_load) begin
        // Sync with load bypasses the shadow entirely.
        act_d  = i_ftw;
        shd_d  = i_ftw;
        pend_d = 1'b0;
      end else if (pend_q) begin
        act_d  = shd_q;
        pend_d = 1'b0;
      end
    end else begin
      // Commit uses the pre-load shadow; a coincident load then re-arms pend.
      if (i_wrap && pend_q) begin
        act_d  = shd_q;
        pend_d = 1'b0;
      end
      if (i_load) begin
        shd_d  = i_ftw;
        pend_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      act_q  <= '0;
      shd_q  <= '0;
      pend_q <= 1'b0;
    end else begin
      act_q  <= act_d;
      shd_q  <= shd_d;
      pend_q <= pend_d;
    end
  end

  assign o_ftw_act = act_q;
  assign o_pend    = pend_q;

endmodule

// File: rtl/phase_acc.sv
// Phase accumulator producing the 16-bit sawtooth phase word for saw2sin.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_en           : sample strobe, one accumulator step per high cycle
//   i_ftw          : new tuning word (unsigned)
//   i_ftw_load     : capture i_ftw into the shadow register
//   i_phase_off    : phase offset added to the output word every step
//   i_sync         : zero the accumulator, priority over i_en
//   o_saw          : registered phase word
//   o_valid        : o_saw updated this cycle
//   o_wrap         : this step carried out of the accumulator
//   o_pending      : shadow tuning word awaiting commit
module phase_acc
  import phase_acc_pkg::*;
#(
  parameter int unsigned ACC_W = ACC_W_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic [ACC_W-1:0] i_ftw,
  input  logic             i_ftw_load,
  input  logic [SAW_W-1:0] i_phase_off,
  input  logic             i_sync,
  output logic [SAW_W-1:0] o_saw,
  output logic             o_valid,
  output logic             o_wrap,
  output logic             o_pending
);

  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_nx;
  logic             carry;
  logic [ACC_W-1:0] ftw_act;
  logic             pend;
  logic             step;
  logic [SAW_W-1:0] saw_nx;
  logic [SAW_W-1:0] saw_q;
  logic             valid_q;
  logic             wrap_q;

  assign step              = i_en & ~i_sync;
  assign {carry, acc_nx}   = {1'b0, acc_q} + {1'b0, ftw_act};
  assign saw_nx            = acc_nx[ACC_W-1 -: SAW_W] + i_phase_off;

  ftw_shadow #(
    .ACC_W (ACC_W)
  ) u_ftw_shadow (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_wrap    (step & carry),
    .i_sync    (i_sync),
    .i_load    (i_ftw_load),
    .i_ftw     (i_ftw),
    .o_ftw_act (ftw_act),
    .o_pend    (pend)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      acc_q   <= '0;
      saw_q   <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else if (i_sync) begin
      acc_q   <= '0;
      saw_q   <= i_phase_off;
      valid_q <= 1'b1;
      wrap_q  <= 1'b0;
    end else if (i_en) begin
      acc_q   <= acc_nx;
      saw_q   <= saw_nx;
      valid_q <= 1'b1;
      wrap_q  <= carry;
    end else begin
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
    end
  end

  assign o_saw     = saw_q;
  assign o_valid   = valid_q;
  assign o_wrap    = wrap_q;
  assign o_pending = pend;

endmodule

// File: tb/tb_phase_acc.sv
// Directed bench for phase_acc with hand-computed expected values.
module tb_phase_acc;
  import phase_acc_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  ftw_t        ftw = '0;
  logic        ftw_load = 1'b0;
  logic [15:0] phase_off = '0;
  logic        sync = 1'b0;
  logic [15:0] saw;
  logic        valid;
  logic        wrap;
  logic        pending;

  int nvec = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  phase_acc #(
    .ACC_W (32)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_en        (en),
    .i_ftw       (ftw),
    .i_ftw_load  (ftw_load),
    .i_phase_off (phase_off),
    .i_sync      (sync),
    .o_saw       (saw),
    .o_valid     (valid),
    .o_wrap      (wrap),
    .o_pending   (pending)
  );

  // Advance one clock and sample 1 time unit after the rising edge.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e, input logic s, input logic ld, input logic [31:0] f,
                       input logic [15:0] off);
    en        = e;
    sync      = s;
    ftw_load  = ld;
    ftw       = f;
    phase_off = off;
  endtask

  task automatic expect_out(input string tag, input logic [15:0] e_saw, input logic e_valid,
                            input logic e_wrap, input logic e_pend);
    nvec++;
    assert (saw === e_saw) else begin
      nfail++;
      $error("FAIL %s o_saw got %h want %h", tag, saw, e_saw);
    end
    nvec++;
    assert (valid === e_valid) else begin
      nfail++;
      $error("FAIL %s o_valid got %b want %b", tag, valid, e_valid);
    end
    nvec++;
    assert (wrap === e_wrap) else begin
      nfail++;
      $error("FAIL %s o_wrap got %b want %b", tag, wrap, e_wrap);
    end
    nvec++;
    assert (pending === e_pend) else begin
      nfail++;
      $error("FAIL %s o_pending got %b want %b", tag, pending, e_pend);
    end
  endtask

  initial begin
    // Reset
    #12;
    expect_out("reset", 16'h0000, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Load + sync at FTW quarter turn, then five strobes
    drive(1'b0, 1'b1, 1'b1, 32'h4000_0000, 16'h0000);
    cycle();
    expect_out("sync_load", 16'h0000, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 16'h0000);
    cycle(); expect_out("q1", 16'h4000, 1'b1, 1'b0, 1'b0);
    cycle(); expect_out("q2", 16'h8000, 1'b1, 1'b0, 1'b0);
    cycle(); expect_out("q3", 16'hC000, 1'b1, 1'b0, 1'b0);
    cycle(); expect_out("q4_wrap", 16'h0000, 1'b1, 1'b1, 1'b0);
    cycle(); expect_out("q5", 16'h4000, 1'b1, 1'b0, 1'b0);

    // Load 2000_0000 at phase 4000; commits at next wrap
    drive(1'b1, 1'b0, 1'b1, 32'h2000_0000, 16'h0000);
    cycle(); expect_out("ld_8000", 16'h8000, 1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 16'h0000);
    cycle(); expect_out("ld_C000", 16'hC000, 1'b1, 1'b0, 1'b1);
    cycle(); expect_out("ld_wrap", 16'h0000, 1'b1, 1'b1, 1'b0);
    cycle(); expect_out("new_2000", 16'h2000, 1'b1, 1'b0, 1'b0);
    cycle(); expect_out("new_4000", 16'h4000, 1'b1, 1'b0, 1'b0);

    // Load A in an idle cycle, load B coincident with committing wrap
    drive(1'b0, 1'b0, 1'b1, 32'h4000_0000, 16'h0000);
    cycle(); expect_out("idle_ldA", 16'h4000, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 16'h0000);
    cycle(); expect_out("a_6000", 16'h6000, 1'b1, 1'b0, 1'b1);
    cycle(); expect_out("a_8000", 16'h8000, 1'b1, 1'b0, 1'b1);
    cycle(); expect_out("a_A000", 16'hA000, 1'b1, 1'b0, 1'b1);
    cycle(); expect_out("a_C000", 16'hC000, 1'b1, 1'b0, 1'b1);
    cycle(); expect_out("a_E000", 16'hE000, 1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b1, 32'h8000_0000, 16'h0000);
    cycle(); expect_out("coinc_wrap", 16'h0000, 1'b1, 1'b1, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 16'h0000);
    cycle(); expect_out("A_4000", 16'h4000, 1'b1, 1'b0, 1'b1);
    cycle(); expect_out("A_8000", 16'h8000, 1'b1, 1'b0, 1'b1);
    cycle(); expect_out("A_C000", 16'hC000, 1'b1, 1'b0, 1'b1);
    cycle(); expect_out("A_wrap", 16'h0000, 1'b1, 1'b1, 1'b0);
    cycle(); expect_out("B_8000", 16'h8000, 1'b1, 1'b0, 1'b0);
    cycle(); expect_out("B_wrap", 16'h0000, 1'b1, 1'b1, 1'b0);

    // Offset 8000 with FTW=0: frozen phase, pending only cleared by sync
    drive(1'b0, 1'b1, 1'b1, 32'h0, 16'h8000);
    cycle(); expect_out("z_sync", 16'h8000, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 16'h8000);
    for (int i = 0; i < 3; i++) begin
      cycle(); expect_out("z_hold", 16'h8000, 1'b1, 1'b0, 1'b0);
    end
    drive(1'b1, 1'b0, 1'b1, 32'h0000_0001, 16'h8000);
    cycle(); expect_out("z_ld1", 16'h8000, 1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 16'h8000);
    for (int i = 0; i < 2; i++) begin
      cycle(); expect_out("z_pend", 16'h8000, 1'b1, 1'b0, 1'b1);
    end
    drive(1'b0, 1'b1, 1'b0, 32'h0, 16'h8000);
    cycle(); expect_out("z_sync_commit", 16'h8000, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 16'h8000);
    cycle(); expect_out("z_ftw1", 16'h8000, 1'b1, 1'b0, 1'b0);

    // Sync priority over en with acc nonzero; en gaps hold o_saw
    drive(1'b0, 1'b1, 1'b1, 32'h4000_0000, 16'h0000);
    cycle(); expect_out("s_sync", 16'h0000, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 16'h0000);
    cycle(); expect_out("s_4000", 16'h4000, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 16'h0000);
    cycle(); expect_out("gap1", 16'h4000, 1'b0, 1'b0, 1'b0);
    cycle(); expect_out("gap2", 16'h4000, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 16'h0123);
    cycle(); expect_out("off_8123", 16'h8123, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 32'h0, 16'h0055);
    cycle(); expect_out("sync_en", 16'h0055, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 16'h0000);
    cycle(); expect_out("after_sync", 16'h4000, 1'b1, 1'b0, 1'b0);

    // Async reset mid-run with pend=1
    drive(1'b1, 1'b0, 1'b1, 32'h1234_0000, 16'h0000);
    cycle(); expect_out("pre_rst", 16'h8000, 1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 16'h0000);
    #2;
    rst_n = 1'b0;
    #1;
    expect_out("async_rst", 16'h0000, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 32'h0, 16'h0000);
    cycle(); expect_out("post_rst", 16'h0000, 1'b1, 1'b0, 1'b0);
    // Shadow was discarded: sync commits nothing, phase stays frozen.
    drive(1'b0, 1'b1, 1'b0, 32'h0, 16'h0000);
    cycle(); expect_out("post_rst_sync", 16'h0000, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 16'h0000);
    cycle(); expect_out("post_rst_step", 16'h0000, 1'b1, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
